// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU stage.
// Build option: ALU_OVF_EN adds the signed-overflow flag.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOR  = 3'b011,
      OP_ADD  = 3'b100,
      OP_SUB  = 3'b101,
      OP_SLT  = 3'b110,
      OP_MULT = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

endpackage

// File: rtl/alu_seq_32bit_if.sv
// Request/response bundle of the ALU stage.
// Build option: ALU_OVF_EN adds the ovf signal.
interface alu_seq_32bit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
`ifdef ALU_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, op, a, b,
`ifdef ALU_OVF_EN
      input  ovf,
`endif
      input  busy, done, result, result_hi, zero
   );

   modport slave (
      input  start, op, a, b,
`ifdef ALU_OVF_EN
      output ovf,
`endif
      output busy, done, result, result_hi, zero
   );

endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Build option: none (ALU_OVF_EN does not affect this unit).
module shift_add_mult #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] prod_next
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   assign prod_next = mplier[0] ? acc + mcand : acc;
   assign last      = step && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= prod_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq_32bit.sv
// Registered multi-cycle ALU stage with start/busy/done handshake.
// Build option: ALU_OVF_EN enables the registered ovf flag.
module alu_seq_32bit
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic            clk,
   input logic            reset,
   alu_seq_32bit_if.slave bus
);

   state_t             state;
   op_t                op;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic               accept;
   logic               load;
   logic               last;
   logic [2*WIDTH-1:0] prod_next;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   hi_q;
   logic               zero_q;
`ifdef ALU_OVF_EN
   logic               ov;
   logic               ovf_q;
`endif

   assign op     = op_t'(bus.op);
   assign sum    = bus.a + bus.b;
   assign diff   = bus.a - bus.b;
   assign accept = bus.start && (state == ST_IDLE);
   assign load   = accept && (op == OP_MULT);

   always_comb begin
      lo = '0;
`ifdef ALU_OVF_EN
      ov = 1'b0;
`endif
      unique case (op)
         OP_AND:  lo = bus.a & bus.b;
         OP_OR:   lo = bus.a | bus.b;
         OP_XOR:  lo = bus.a ^ bus.b;
         OP_NOR:  lo = ~(bus.a | bus.b);
         OP_ADD: begin
            lo = sum;
`ifdef ALU_OVF_EN
            ov = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.a[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            lo = diff;
`ifdef ALU_OVF_EN
            ov = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.a[WIDTH-1]);
`endif
         end
         OP_SLT:  lo = {{(WIDTH-1){1'b0}},
                        $signed(bus.a) < $signed(bus.b)};
         default: lo = '0;
      endcase
   end

   shift_add_mult #(.WIDTH(WIDTH)) u_mult (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (state == ST_MUL),
      .a         (bus.a),
      .b         (bus.b),
      .last      (last),
      .prod_next (prod_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         res_q  <= '0;
         hi_q   <= '0;
         zero_q <= 1'b1;
`ifdef ALU_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept && op == OP_MULT) begin
                  state  <= ST_MUL;
                  busy_q <= 1'b1;
               end else if (accept) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  res_q  <= lo;
                  hi_q   <= '0;
                  zero_q <= (lo == '0);
`ifdef ALU_OVF_EN
                  ovf_q  <= ov;
`endif
               end
            end
            ST_MUL: begin
               // Product is only published on the final step.
               if (last) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  res_q  <= prod_next[WIDTH-1:0];
                  hi_q   <= prod_next[2*WIDTH-1:WIDTH];
                  zero_q <= (prod_next == '0);
`ifdef ALU_OVF_EN
                  ovf_q  <= 1'b0;
`endif
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = res_q;
   assign bus.result_hi = hi_q;
   assign bus.zero      = zero_q;
`ifdef ALU_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_32bit.sv
// Self-checking bench for alu_seq_32bit: vector table, corner sequences, random ops.
// Build option: ALU_OVF_EN also checks the ovf flag.
module tb_alu_seq_32bit;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu_seq_32bit_if #(.WIDTH(32)) bus ();

   alu_seq_32bit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic        z;
      logic        ov;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model from arithmetic definitions.
   task automatic model(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] lo,
                        output logic [31:0] hi, output logic z,
                        output logic ov);
      longint sx, sy, s;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = 64'(x) * 64'(y);
      hi = '0;
      ov = 1'b0;
      case (o)
         3'd0: lo = x & y;
         3'd1: lo = x | y;
         3'd2: lo = x ^ y;
         3'd3: lo = ~(x | y);
         3'd4: begin
            s  = sx + sy;
            lo = 32'(s);
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd5: begin
            s  = sx - sy;
            lo = 32'(s);
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd6: lo = (sx < sy) ? 32'd1 : 32'd0;
         default: begin
            lo = p[31:0];
            hi = p[63:32];
         end
      endcase
      z = ({hi, lo} == 64'd0);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er,
                         input logic [31:0] eh, input logic ez,
                         input logic eo);
      int n;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (o == 3'b111) begin
         chk("mul_busy_set", 64'(bus.busy), 64'd1);
         n = 0;
         while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("mul_latency", 64'(n), 64'd32);
      end else begin
         chk("done_latency", 64'(bus.done), 64'd1);
      end
      chk("result", 64'(bus.result), 64'(er));
      chk("result_hi", 64'(bus.result_hi), 64'(eh));
      chk("zero", 64'(bus.zero), 64'(ez));
      chk("busy_clear", 64'(bus.busy), 64'd0);
`ifdef ALU_OVF_EN
      chk("ovf", 64'(bus.ovf), 64'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected X in ovf expectation");
`endif
      @(posedge clk);
      #1;
      chk("done_width", 64'(bus.done), 64'd0);
   endtask

   initial begin
      logic [31:0] el, eh;
      logic ez, eo;
      logic [2:0] o;
      logic [31:0] x, y;
      int ndone;

      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;

      tbl.push_back('{3'd1, 32'h12311111, 32'h00100000, 32'h12311111, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd3, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 1'b0});
      tbl.push_back('{3'd5, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd6, 32'h00000001, 32'h00000002, 32'h00000001, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd6, 32'h80000000, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd6, 32'h00000001, 32'h80000000, 32'h00000000, 32'h0, 1'b1, 1'b0});
      tbl.push_back('{3'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1});
      tbl.push_back('{3'd5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1});
      tbl.push_back('{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0});
      tbl.push_back('{3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd2, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0});
      tbl.push_back('{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0});
      tbl.push_back('{3'd7, 32'h00000000, 32'h00001234, 32'h00000000, 32'h0, 1'b1, 1'b0});
      tbl.push_back('{3'd7, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b0, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_hi", 64'(bus.result_hi), 64'd0);
      chk("rst_zero", 64'(bus.zero), 64'd1);
`ifdef ALU_OVF_EN
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
      reset = 1'b0;

      foreach (tbl[i])
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                tbl[i].hi, tbl[i].z, tbl[i].ov);

      // Start pulse mid-MUL must be ignored.
      bus.op = 3'd7; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.op = 3'd1; bus.a = 32'h1; bus.b = 32'h2; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("mid_mul_done_cnt", 64'(ndone), 64'd1);
      chk("mid_mul_lo", 64'(bus.result), 64'h1);
      chk("mid_mul_hi", 64'(bus.result_hi), 64'hFFFFFFFE);

      // Reset during MUL aborts without a done pulse.
      bus.op = 3'd7; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_result", 64'(bus.result), 64'd0);
      chk("abort_hi", 64'(bus.result_hi), 64'd0);
      chk("abort_zero", 64'(bus.zero), 64'd1);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      run_op(3'd1, 32'h12311111, 32'h00100000, 32'h12311111, 32'h0,
             1'b0, 1'b0);

      // Held start: accept every other edge, done alternates.
      bus.op = 3'd0; bus.a = 32'hF0F0F0F0; bus.b = 32'hFF00FF00;
      bus.start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("held_done", 64'(bus.done), 64'((i % 2) == 0));
         chk("held_result", 64'(bus.result), 64'hF000F000);
      end
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = $urandom;
         if (i % 5 == 0) y = x;
         model(o, x, y, el, eh, ez, eo);
         run_op(o, x, y, el, eh, ez, eo);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
